// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the multi-channel PWM controller.
//   MODE_EDGE / MODE_CENTER : values of the mode input.
//   ADDR_PERIOD             : configuration address of the period register.
//   addr_w(n_ch)            : width of the configuration address bus.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int ADDR_PERIOD = 0;

  // One address for the period plus one per channel duty.
  function automatic int addr_w(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output channel.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : 0 forces the output to its idle level (polarity)
//   wr_en      : write strobe for this channel's staging duty
//   wdata      : duty value to stage
//   upd        : staging-to-active transfer at this edge
//   cnt        : shared period counter
//   polarity   : 1 = active-low output
//   pwm        : registered PWM output
module pwm_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wdata,
  input  logic             upd,
  input  logic [CNT_W-1:0] cnt,
  input  logic             polarity,
  output logic             pwm
);

  logic [CNT_W-1:0] stg_duty;
  logic [CNT_W-1:0] act_duty;
  logic [CNT_W-1:0] stg_duty_nxt;

  // A write landing on the transfer edge goes straight through to active.
  assign stg_duty_nxt = wr_en ? wdata : stg_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_duty <= '0;
      act_duty <= '0;
      pwm      <= 1'b0;
    end else begin
      stg_duty <= stg_duty_nxt;
      if (upd) begin
        act_duty <= stg_duty_nxt;
      end
      pwm <= enable ? ((cnt < act_duty) ^ polarity) : polarity;
    end
  end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl: N-channel PWM generator with one shared period counter.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : 1 = run; 0 = counter held at 0, outputs idle (= polarity)
//   mode         : 0 = edge-aligned, 1 = center-aligned (sampled at boundary)
//   polarity     : per-channel output inversion
//   upd_lock     : 1 = hold active registers (atomic multi-channel update)
//   cfg_we       : configuration write strobe
//   cfg_addr     : 0 = period, k = duty of channel k-1, > N_CH ignored
//   cfg_wdata    : configuration write data
//   pwm_out      : registered PWM outputs
//   period_tick  : high on the last cycle of each period
//
// Handshake: there is none on the configuration port; every cycle with
// cfg_we=1 is a complete write into the staging registers. Staged values
// become active only on a period boundary (or every cycle while disabled),
// unless upd_lock is high.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int               N_CH       = 4,
  parameter int               CNT_W      = 8,
  parameter logic [CNT_W-1:0] DEF_PERIOD = {CNT_W{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [N_CH-1:0]           polarity,
  input  logic                      upd_lock,
  input  logic                      cfg_we,
  input  logic [addr_w(N_CH)-1:0]   cfg_addr,
  input  logic [CNT_W-1:0]          cfg_wdata,
  output logic [N_CH-1:0]           pwm_out,
  output logic                      period_tick
);

  localparam int AW = addr_w(N_CH);

  // Counter direction FSM.
  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stg_period;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] stg_period_nxt;
  logic             act_mode;
  logic             tick;
  logic             upd;
  logic             last_up;
  logic             wr_period;

  // Boundary decode. A zero period makes every cycle a boundary.
  always_comb begin
    tick = 1'b0;
    if (enable) begin
      if (act_period == '0) begin
        tick = 1'b1;
      end else if (act_mode == MODE_EDGE) begin
        tick = (cnt == act_period);
      end else begin
        tick = (state == ST_DOWN) && (cnt == '0);
      end
    end
  end

  assign period_tick = tick;
  assign last_up     = (cnt == (act_period - CNT_W'(1)));
  assign upd         = !upd_lock && (!enable || tick);

  assign wr_period      = cfg_we && (cfg_addr == AW'(ADDR_PERIOD));
  assign stg_period_nxt = wr_period ? cfg_wdata : stg_period;

  // Counter / direction. Every boundary restarts at 0 counting up, which is
  // also where a new mode or period starts from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= ST_UP;
    end else if (!enable || tick) begin
      cnt   <= '0;
      state <= ST_UP;
    end else if (act_mode == MODE_EDGE) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      case (state)
        ST_UP: begin
          // Top endpoint is held for a second cycle while turning around.
          if (last_up) begin
            state <= ST_DOWN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= cnt - CNT_W'(1);
        end
      endcase
    end
  end

  // Period and mode staging/active registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_period <= DEF_PERIOD;
      act_period <= DEF_PERIOD;
      act_mode   <= MODE_EDGE;
    end else begin
      stg_period <= stg_period_nxt;
      if (upd) begin
        act_period <= stg_period_nxt;
        act_mode   <= mode;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .wr_en   (cfg_we && (cfg_addr == AW'(i + 1))),
      .wdata   (cfg_wdata),
      .upd     (upd),
      .cnt     (cnt),
      .polarity(polarity[i]),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: doc/pwm_multi_ctrl.md
Name: pwm_multi_ctrl

Overview:
- N-channel PWM generator for LED brightness control; generalises the fixed 2-bit duty selector to programmable period, per-channel duty, polarity and edge/center-aligned modes.
- One shared period counter drives N per-channel comparators.
- Configuration is written through a simple register-write port into staging registers.
- Staging values move to the active registers only at a period boundary, so outputs never glitch mid-period.

Parameters:
- N_CH, 4, number of PWM channels (1..16)
- CNT_W, 8, counter/duty/period width in bits (2..16)
- DEF_PERIOD, 2**CNT_W-1, reset value of the period register

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = run; 0 = counter held, outputs idle
- mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at boundary
- polarity  in  N_CH  per-channel output inversion (1 = active-low)
- upd_lock  in  1  1 = block staging-to-active transfer (atomic multi-channel update)
- cfg_we  in  1  write strobe
- cfg_addr  in  clog2(N_CH+1)  0 = period, k = duty of channel k-1
- cfg_wdata  in  CNT_W  write data
- pwm_out  out  N_CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse on the last cycle of each period

Behaviour:
- Reset:
  - pwm_out=0, period_tick=0, cnt=0, dir=up.
  - Staging and active period = DEF_PERIOD; staging and active duties = 0; active mode = 0.
- Writes:
  - cfg_we=1 updates the staging register at cfg_addr on the next edge.
  - Writes to cfg_addr > N_CH are ignored.
  - Writes are accepted regardless of enable.
- Boundary (tick):
  - If upd_lock=0, active <= staging for period, all duties and mode, on the tick cycle's edge.
  - A write coinciding with the tick bypasses into active (new data wins).
  - If upd_lock=1, active registers hold; period_tick still pulses.
- Edge mode (P = active period):
  - cnt runs 0..P then wraps to 0; period = P+1 cycles.
  - tick when cnt==P.
- Center mode:
  - cnt runs 0,1..P-1 up, then P-1..0 down; each endpoint is held twice; period = 2P cycles.
  - dir flips at cnt==P-1 (up) and at cnt==0 (down).
  - tick when cnt==0 and dir==down.
- P==0 (either mode): cnt stays 0; tick every cycle.
- Compare: raw[i] = (cnt < D[i]); pwm_out[i] <= raw[i] XOR polarity[i].
  - Latency is one cycle from cnt to pin.
  - D=0 gives constant inactive.
  - Edge mode: D ≥ P+1 gives constant active (100%); high time is min(D,P+1) of P+1 cycles.
  - Center mode: high time is 2·min(D,P) of 2P cycles, symmetric about the period midpoint.
- enable=0:
  - cnt<=0, dir<=up, period_tick=0, pwm_out<=polarity (idle).
  - Staging-to-active transfer occurs every cycle while disabled, unless upd_lock=1.
- enable rising: the period starts at cnt=0 on the next cycle.
- Active period shrunk below the current cnt: impossible mid-period, because the period changes only at a boundary.
- Mode change takes effect only at a boundary; the counter restarts at 0/up.
- rst asserted mid-operation: all state returns to reset values immediately and asynchronously.

Decomposition:
- Package pwm_pkg:
  - MODE_EDGE=1'b0, MODE_CENTER=1'b1
  - ADDR_PERIOD=0
  - function addr_w(N_CH) = clog2(N_CH+1)
- Sub-module pwm_channel:
  - Per channel: staging/active duty registers, comparator, polarity XOR and output flop.
  - Instantiated N_CH times by generate.
- Top-level module contains: counter/direction FSM (states UP, DOWN), boundary logic, write decode.

Test Plan:
- Reset then enable=1, mode=0, period=9, ch0 duty=3, polarity=0 -> pwm_out[0] high 3 of every 10 cycles; period_tick every 10th cycle; first high one cycle after cnt=0.
- Edge mode, period=9, duties {0,10,15,5} -> ch0 constant 0, ch1 and ch2 constant 1, ch3 50%; polarity=4'b0001 -> ch0 constant 1.
- Center mode, period=8, duty=2 -> 16-cycle period; high cycles at cnt 0,1 (up) and 1,0 (down), i.e. 4 contiguous cycles straddling the wrap; tick at the down-count 0.
- Write duty=7 mid-period with upd_lock=0 -> old duty persists until the tick; new duty from next period. Same with upd_lock=1 across 3 ticks -> no change until lock released.
- Write coincident with period_tick -> new value used in the immediately following period; period=0 write -> tick every cycle, duty≥1 output constant active.
- Toggle enable=0 mid-period -> pwm_out = polarity next cycle, cnt=0; rst pulse mid-period -> pwm_out=0, duties=0, period=DEF_PERIOD, asynchronously.
